quadrature_decoder_sar: RTL

Decodes a two-phase quadrature encoder (qa/qb) into direction and step pulses, and keeps a position count.
Acts as the producing end of the up/down counting interface: up_down and step are formatted so a reversible counter can consume them directly.
The block also maintains its own wrap-around position count, so it can stand alone on an encoder input.
Sits between asynchronous board-level encoder pins and the counting/display logic.

---
 rtl/quadrature_decoder_sar_pkg.sv | 52 +++++
 rtl/quadrature_decoder_sar_filter.sv | 78 +++++++
 rtl/quadrature_decoder_sar.sv | 120 ++++++++++++
 3 files changed

// File: rtl/quadrature_decoder_sar_pkg.sv
// Shared encodings for the quadrature decoder: phase codes, FSM states,
// direction values and the transition classifier.
package quadrature_decoder_sar_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MOV_NONE = 2'd0,
    MOV_UP   = 2'd1,
    MOV_DN   = 2'd2,
    MOV_ERR  = 2'd3
  } move_e;

  // Successor of a phase when A leads B (counting up).
  function automatic logic [1:0] up_next(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      PH_01:   nxt = PH_00;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic move_e classify(input logic [1:0] prev, input logic [1:0] curr);
    move_e mv;
    if (curr == up_next(prev)) begin
      mv = MOV_UP;
    end else if (prev == up_next(curr)) begin
      mv = MOV_DN;
    end else if (curr == ~prev) begin
      mv = MOV_ERR;
    end else begin
      mv = MOV_NONE;
    end
    return mv;
  endfunction

endpackage

// File: rtl/quadrature_decoder_sar_filter.sv
// Two-flop synchroniser plus FILT_LEN-sample glitch filter for both encoder
// phases; emits the filtered phase, a change strobe and a settled flag.
module quad_phase_filter #(
  parameter int FILT_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qa,
  input  logic       qb,
  output logic [1:0] phase,
  output logic       change,
  output logic       stable
);
  import quadrature_decoder_sar_pkg::*;

  localparam logic [3:0] FILT_CNT = 4'(FILT_LEN);

  logic [1:0] sync1_r, sync2_r, vld_r, cand_r, filt_r;
  logic [3:0] fcnt_r;
  logic       change_r, stable_r;
  logic [1:0] cand_s, filt_s;
  logic [3:0] fcnt_s;
  logic       change_s;

  // Counting is held off until the synchroniser holds real samples, so a
  // phase present at reset release is seen as a change rather than as 00.
  always_comb begin
    cand_s   = cand_r;
    fcnt_s   = fcnt_r;
    filt_s   = filt_r;
    change_s = 1'b0;
    if (!vld_r[1]) begin
      fcnt_s = 4'd0;
    end else if (sync2_r != cand_r) begin
      cand_s = sync2_r;
      fcnt_s = 4'd1;
    end else if (fcnt_r < FILT_CNT) begin
      fcnt_s = fcnt_r + 4'd1;
    end else begin
      fcnt_s = fcnt_r;
    end
    if ((fcnt_s == FILT_CNT) && (cand_s != filt_r)) begin
      filt_s   = cand_s;
      change_s = 1'b1;
    end else begin
      filt_s   = filt_r;
      change_s = 1'b0;
    end
  end

  // Synchroniser, filter state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= PH_00;
      sync2_r  <= PH_00;
      vld_r    <= 2'b00;
      cand_r   <= PH_00;
      fcnt_r   <= 4'd0;
      filt_r   <= PH_00;
      change_r <= 1'b0;
      stable_r <= 1'b0;
    end else begin
      sync1_r  <= {qa, qb};
      sync2_r  <= sync1_r;
      vld_r    <= {vld_r[0], 1'b1};
      cand_r   <= cand_s;
      fcnt_r   <= fcnt_s;
      filt_r   <= filt_s;
      change_r <= change_s;
      stable_r <= (fcnt_s == FILT_CNT);
    end
  end

  assign phase  = filt_r;
  assign change = change_r;
  assign stable = stable_r;

endmodule

// File: rtl/quadrature_decoder_sar.sv
// Quadrature decoder: classifies filtered phase transitions into step/direction
// pulses, flags double transitions and keeps a wrapping position count.
module quadrature_decoder_sar #(
  parameter int CNT_W    = 4,
  parameter int FILT_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr,
  output logic             step,
  output logic             up_down,
  output logic [CNT_W-1:0] cnt,
  output logic             err,
  output logic             err_sticky
);
  import quadrature_decoder_sar_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       phase_s;
  logic             change_s, stable_s;
  state_e           state_r, state_s;
  logic [1:0]       prev_r, prev_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             up_down_r, up_down_s;
  logic             step_r, step_s, err_r, err_s, sticky_r, sticky_s;
  move_e            mv_s;

  quad_phase_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk    (clk),
    .rst    (rst),
    .qa     (qa),
    .qb     (qb),
    .phase  (phase_s),
    .change (change_s),
    .stable (stable_s)
  );

  // Next-state, classification and counter update.
  always_comb begin
    state_s   = state_r;
    prev_s    = prev_r;
    cnt_s     = cnt_r;
    up_down_s = up_down_r;
    step_s    = 1'b0;
    err_s     = 1'b0;
    mv_s      = MOV_NONE;
    case (state_r)
      INIT: begin
        prev_s = phase_s;
        if (change_s || stable_s) begin
          state_s = TRACK;
        end else begin
          state_s = INIT;
        end
      end
      TRACK: begin
        if (change_s) begin
          prev_s = phase_s;
          mv_s   = classify(prev_r, phase_s);
        end else begin
          prev_s = prev_r;
        end
      end
      default: state_s = INIT;
    endcase
    case (mv_s)
      MOV_UP: begin
        step_s    = 1'b1;
        up_down_s = DIR_UP;
        cnt_s     = cnt_r + CNT_ONE;
      end
      MOV_DN: begin
        step_s    = 1'b1;
        up_down_s = DIR_DN;
        cnt_s     = cnt_r - CNT_ONE;
      end
      MOV_ERR: err_s = 1'b1;
      default: step_s = 1'b0;
    endcase
    // A fresh error survives a simultaneous clear.
    if (clr) begin
      cnt_s    = CNT_ZERO;
      sticky_s = err_s;
    end else begin
      sticky_s = sticky_r | err_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= INIT;
      prev_r    <= PH_00;
      cnt_r     <= CNT_ZERO;
      up_down_r <= DIR_UP;
      step_r    <= 1'b0;
      err_r     <= 1'b0;
      sticky_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      prev_r    <= prev_s;
      cnt_r     <= cnt_s;
      up_down_r <= up_down_s;
      step_r    <= step_s;
      err_r     <= err_s;
      sticky_r  <= sticky_s;
    end
  end

  assign step       = step_r;
  assign up_down    = up_down_r;
  assign cnt        = cnt_r;
  assign err        = err_r;
  assign err_sticky = sticky_r;

endmodule
